vacancy_display_ctrl: RTL and testbench

//   Tracks parking-lot occupancy from entry/exit sensors and keeps free = CAPACITY - busy.

---
 rtl/vacancy_display_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_vacancy_display_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vacancy_display_ctrl.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// vacancy_display_ctrl
//
// Purpose:
//   Counts occupied parking spaces from entry/exit sensor levels and derives
//   the free-space count and full/empty flags. It also sequences the 2-bit
//   display select that walks a downstream 4-bit mux through
//   free count -> free tag -> busy count -> busy tag. Each phase is shown for
//   DWELL clock cycles.
//
// Parameters:
//   CAPACITY  total spaces, 1..15 (counts are 4 bits wide)
//   DWELL     clock cycles per display phase, >= 1
//
// Ports:
//   clk      in   1  system clock, rising edge
//   reset    in   1  asynchronous, active-high; clears all state
//   car_in   in   1  entry sensor level, asynchronous to clk
//   car_out  in   1  exit sensor level, asynchronous to clk
//   hold     in   1  1 = freeze display sequencing (counts still update)
//   free     out  4  CAPACITY - busy
//   busy     out  4  occupied spaces, 0..CAPACITY
//   cont     out  2  display select: 00 free, 01 free tag, 10 busy, 11 busy tag
//   full     out  1  busy == CAPACITY
//   empty    out  1  busy == 0
//   reject   out  1  one-cycle pulse: entry while full, or exit while empty
// -----------------------------------------------------------------------------
module vacancy_display_ctrl #(
  parameter int unsigned CAPACITY = 9,
  parameter int unsigned DWELL    = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       car_in,
  input  logic       car_out,
  input  logic       hold,
  output logic [3:0] free,
  output logic [3:0] busy,
  output logic [1:0] cont,
  output logic       full,
  output logic       empty,
  output logic       reject
);

  localparam int unsigned    CW         = $clog2(DWELL + 1);
  localparam logic [3:0]     CAP4       = 4'(CAPACITY);
  localparam logic [CW-1:0]  DWELL_LAST = CW'(DWELL - 1);

  typedef enum logic [1:0] {
    S_FREE  = 2'b00,
    S_TAG_F = 2'b01,
    S_BUSY  = 2'b10,
    S_TAG_B = 2'b11
  } state_t;

  // ---------------------------------------------------------------------------
  // Sensor path. Bit 0 is the entry sensor, bit 1 the exit sensor.
  // r_sync1/r_sync2 form the two-flop synchronizer; r_dly is the previous
  // synchronized value, so a held level yields a single one-cycle edge.
  // ---------------------------------------------------------------------------
  logic [1:0] w_sensor_raw;
  logic [1:0] r_sync1;
  logic [1:0] r_sync2;
  logic [1:0] r_dly;
  logic       w_in_edge;
  logic       w_out_edge;

  assign w_sensor_raw = {car_out, car_in};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
      r_dly   <= 2'b00;
    end else begin
      r_sync1 <= w_sensor_raw;
      r_sync2 <= r_sync1;
      r_dly   <= r_sync2;
    end
  end

  assign w_in_edge  = r_sync2[0] & ~r_dly[0];
  assign w_out_edge = r_sync2[1] & ~r_dly[1];

  // ---------------------------------------------------------------------------
  // Occupancy counter. Simultaneous entry and exit edges cancel: the count is
  // unchanged, nothing is rejected and the display is not restarted.
  // ---------------------------------------------------------------------------
  logic [3:0] r_busy;
  logic [3:0] w_busy_next;
  logic       r_reject;
  logic       w_reject_next;
  logic       w_accept;

  always_comb begin
    w_busy_next   = r_busy;
    w_reject_next = 1'b0;
    w_accept      = 1'b0;
    if (w_in_edge && !w_out_edge) begin
      if (r_busy < CAP4) begin
        w_busy_next = r_busy + 4'd1;
        w_accept    = 1'b1;
      end else begin
        w_reject_next = 1'b1;
      end
    end else if (w_out_edge && !w_in_edge) begin
      if (r_busy != 4'd0) begin
        w_busy_next = r_busy - 4'd1;
        w_accept    = 1'b1;
      end else begin
        w_reject_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy   <= 4'd0;
      r_reject <= 1'b0;
    end else begin
      r_busy   <= w_busy_next;
      r_reject <= w_reject_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Display sequencer. An accepted event jumps straight back to the free
  // count with a fresh dwell, so the new number is shown for a full phase
  // even while hold is asserted.
  // ---------------------------------------------------------------------------
  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FREE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (w_accept) begin
      w_state_next = S_FREE;
      w_cnt_next   = '0;
    end else if (!hold) begin
      if (r_cnt == DWELL_LAST) begin
        w_cnt_next = '0;
        case (r_state)
          S_FREE:  w_state_next = S_TAG_F;
          S_TAG_F: w_state_next = S_BUSY;
          S_BUSY:  w_state_next = S_TAG_B;
          S_TAG_B: w_state_next = S_FREE;
          default: w_state_next = S_FREE;
        endcase
      end else begin
        w_cnt_next = r_cnt + CW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. cont comes directly from the state register, so it changes on
  // the same edge as busy when an event restarts the display. The flags and
  // free count decode from the busy register, so an asynchronous reset shows
  // up on every output without waiting for a clock.
  // ---------------------------------------------------------------------------
  assign busy   = r_busy;
  assign free   = CAP4 - r_busy;
  assign full   = (r_busy == CAP4);
  assign empty  = (r_busy == 4'd0);
  assign reject = r_reject;
  assign cont   = r_state;

endmodule

// File: tb/tb_vacancy_display_ctrl.sv
`timescale 1ns / 1ps
module tb_vacancy_display_ctrl;

  localparam int CAP = 9;
  localparam int DW  = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       car_in;
  logic       car_out;
  logic       hold;
  logic [3:0] free;
  logic [3:0] busy;
  logic [1:0] cont;
  logic       full;
  logic       empty;
  logic       reject;

  int n_tests = 0;
  int n_fail  = 0;

  vacancy_display_ctrl #(.CAPACITY(CAP), .DWELL(DW)) dut (
    .clk     (clk),
    .reset   (reset),
    .car_in  (car_in),
    .car_out (car_out),
    .hold    (hold),
    .free    (free),
    .busy    (busy),
    .cont    (cont),
    .full    (full),
    .empty   (empty),
    .reject  (reject)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic in_v;
    logic out_v;
    int   exp_busy;
    int   exp_rej;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) until cont has just changed to v; returns 1 ns after
  // that edge, so the dwell counter is at 0.
  task automatic wait_cont_enter(input logic [1:0] v);
    logic [1:0] prev;
    bit found;
    found = 1'b0;
    prev  = cont;
    for (int i = 0; i < 64 && !found; i++) begin
      tick();
      if (prev != v && cont == v) found = 1'b1;
      prev = cont;
    end
    if (!found) check("wait_cont_enter timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bit stayed;
    int rej_cnt;

    // Expected results worked out by hand, starting from busy=0.
    vecs[0] = '{1'b0, 1'b1, 0, 1};            // exit while empty
    for (int i = 1; i <= 9; i++)
      vecs[i] = '{1'b1, 1'b0, i, 0};           // fill up to 9
    vecs[10] = '{1'b1, 1'b0, 9, 1};           // entry while full
    vecs[11] = '{1'b1, 1'b1, 9, 0};           // both at once while full
    vecs[12] = '{1'b0, 1'b1, 8, 0};
    vecs[13] = '{1'b0, 1'b1, 7, 0};
    vecs[14] = '{1'b0, 1'b1, 6, 0};
    vecs[15] = '{1'b0, 1'b1, 5, 0};
    vecs[16] = '{1'b1, 1'b1, 5, 0};           // both at once mid-range

    reset   = 1'b1;
    car_in  = 1'b0;
    car_out = 1'b0;
    hold    = 1'b0;

    // ---- Reset values and the plain display cycle ----
    repeat (3) @(negedge clk);
    check("rst busy", int'(busy), 0);
    check("rst free", int'(free), 9);
    check("rst empty", int'(empty), 1);
    check("rst full", int'(full), 0);
    check("rst reject", int'(reject), 0);
    reset = 1'b0;
    #1;
    check("cycle cont k=0", int'(cont), 0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("cycle cont k=%0d", k), int'(cont), (k / 4) % 4);
    end
    $display("[TB] display cycle checked");

    // ---- Held entry level: one event, latency 2 edges, dwell restart ----
    wait_cont_enter(2'b10);
    car_in = 1'b1;
    tick();                                   // edge N: first sample
    tick();                                   // edge N+1
    check("latency busy@N+1", int'(busy), 0);
    tick();                                   // edge N+2
    check("latency busy@N+2", int'(busy), 1);
    check("latency cont@N+2", int'(cont), 0);
    repeat (3) tick();
    check("restart cont@N+5", int'(cont), 0);
    tick();
    check("restart cont@N+6", int'(cont), 1);
    rej_cnt = 0;
    for (int i = 0; i < 94; i++) begin
      tick();
      rej_cnt += int'(reject);
    end
    check("held level busy", int'(busy), 1);
    check("held level rejects", rej_cnt, 0);
    car_in = 1'b0;
    repeat (4) tick();
    $display("[TB] held entry checked busy=%0d", busy);

    // ---- hold entered one cycle into the busy phase ----
    wait_cont_enter(2'b10);
    tick();
    hold   = 1'b1;
    stayed = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cont != 2'b10) stayed = 1'b0;
    end
    check("hold frozen", int'(stayed), 1);
    hold = 1'b0;
    tick();
    check("hold release +1", int'(cont), 2);
    tick();
    check("hold release +2", int'(cont), 2);
    tick();
    check("hold release +3", int'(cont), 3);

    // ---- entry during hold still restarts the display ----
    wait_cont_enter(2'b01);
    tick();
    hold   = 1'b1;
    car_in = 1'b1;
    tick();
    tick();
    check("hold entry busy before", int'(busy), 1);
    tick();
    check("hold entry busy", int'(busy), 2);
    check("hold entry cont", int'(cont), 0);
    car_in = 1'b0;
    repeat (5) tick();
    check("hold entry cont frozen", int'(cont), 0);
    hold = 1'b0;
    repeat (3) tick();
    check("after hold cont +3", int'(cont), 0);
    tick();
    check("after hold cont +4", int'(cont), 1);
    $display("[TB] hold behaviour checked");

    // ---- simultaneous edges at busy=3 leave the display alone ----
    car_in = 1'b1;
    repeat (3) tick();
    car_in = 1'b0;
    repeat (4) tick();
    check("busy reach 3", int'(busy), 3);
    wait_cont_enter(2'b01);
    car_in  = 1'b1;
    car_out = 1'b1;
    rej_cnt = 0;
    repeat (3) begin
      tick();
      rej_cnt += int'(reject);
    end
    check("both busy", int'(busy), 3);
    check("both cont", int'(cont), 1);
    tick();
    rej_cnt += int'(reject);
    check("both cont advance", int'(cont), 2);
    check("both rejects", rej_cnt, 0);
    car_in  = 1'b0;
    car_out = 1'b0;
    repeat (4) tick();
    $display("[TB] simultaneous edges checked");

    // ---- table-driven event vectors ----
    do_reset();
    for (int v = 0; v < 17; v++) begin
      @(negedge clk);
      car_in  = vecs[v].in_v;
      car_out = vecs[v].out_v;
      rej_cnt = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        rej_cnt += int'(reject);
        if (i == 2) begin
          car_in  = 1'b0;
          car_out = 1'b0;
        end
      end
      check($sformatf("vec%0d busy", v), int'(busy), vecs[v].exp_busy);
      check($sformatf("vec%0d free", v), int'(free), CAP - vecs[v].exp_busy);
      check($sformatf("vec%0d full", v), int'(full), int'(vecs[v].exp_busy == CAP));
      check($sformatf("vec%0d empty", v), int'(empty), int'(vecs[v].exp_busy == 0));
      check($sformatf("vec%0d reject pulses", v), rej_cnt, vecs[v].exp_rej);
      $display("[TB] vec %0d in=%b out=%b busy=%0d free=%0d rejects=%0d",
               v, vecs[v].in_v, vecs[v].out_v, busy, free, rej_cnt);
    end

    // ---- asynchronous reset between edges ----
    wait_cont_enter(2'b10);
    check("pre-reset busy", int'(busy), 5);
    #2;
    reset = 1'b1;
    #1;
    check("async rst busy", int'(busy), 0);
    check("async rst free", int'(free), 9);
    check("async rst cont", int'(cont), 0);
    check("async rst empty", int'(empty), 1);
    check("async rst full", int'(full), 0);

    // ---- sensor level high across reset release is a new event ----
    car_in = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tick();
    tick();
    check("post-reset level busy@2", int'(busy), 0);
    tick();
    check("post-reset level busy@3", int'(busy), 1);
    car_in = 1'b0;
    repeat (3) tick();
    $display("[TB] reset behaviour checked");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
